// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter FSM states, default datapath sizing
// and the BCD digit-count legality check.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   localparam int CALC_WIDTH  = 8;
   localparam int CALC_DIGITS = 3;

   // True when DIGITS decimal digits can hold every WIDTH-bit magnitude.
   function automatic bit digits_fit(input int width, input int digits);
      longint unsigned p10;
      longint unsigned maxv;
      p10 = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p10 = p10 * 64'd10;
      end
      maxv = (64'd1 << width) - 64'd1;
      return (p10 > maxv);
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the ALU side and the binary-to-BCD converter.
interface bin2bcd_seq_if
   import calc_pkg::*;
#(
   parameter int WIDTH  = CALC_WIDTH,
   parameter int DIGITS = CALC_DIGITS
);

   logic                  start;
   logic [WIDTH-1:0]      operand;
   logic                  is_signed;
   logic                  busy;
   logic                  done;
   logic                  neg;
   logic [4*DIGITS-1:0]   bcd;

   modport master (
      output start, operand, is_signed,
      input  busy, done, neg, bcd
   );

   modport slave (
      input  start, operand, is_signed,
      output busy, done, neg, bcd
   );

endinterface

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] nibble_i,
   output logic [3:0] nibble_o
);

   always_comb begin
      nibble_o = nibble_i;
      if (nibble_i >= 4'd5) begin
         nibble_o = nibble_i + 4'd3;
      end else begin
         nibble_o = nibble_i;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with
// optional two's complement input; result feeds the 7-segment digit decoders.
module bin2bcd_seq
   import calc_pkg::*;
#(
   parameter int WIDTH  = CALC_WIDTH,
   parameter int DIGITS = CALC_DIGITS
) (
   input  logic         clk,
   input  logic         rst_n,
   bin2bcd_seq_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = 4 * DIGITS;

   if ((WIDTH < 4) || (WIDTH > 16) || !digits_fit(WIDTH, DIGITS)) begin : g_param_check
      $error("bin2bcd_seq: WIDTH must be 4..16 and DIGITS must cover 2**WIDTH-1");
   end

   conv_state_e      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic             sign_q, sign_d;
   logic [AW-1:0]    bcd_q, bcd_d;
   logic             neg_q, neg_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [AW-1:0]    acc_adj_s;
   logic [WIDTH-1:0] mag_s;
   logic             in_neg_s;
   logic             unused_acc_msb_s;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble_i (acc_q[4*g +: 4]),
         .nibble_o (acc_adj_s[4*g +: 4])
      );
   end

   // The top accumulator bit never carries out for legal DIGITS.
   assign unused_acc_msb_s = acc_adj_s[AW-1];

   // WIDTH-bit negation is exact here: the largest magnitude is 2**(WIDTH-1).
   always_comb begin
      in_neg_s = bus.is_signed & bus.operand[WIDTH-1];
      mag_s    = bus.operand;
      if (in_neg_s) begin
         mag_s = {WIDTH{1'b0}} - bus.operand;
      end else begin
         mag_s = bus.operand;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      acc_d   = acc_q;
      count_d = count_q;
      sign_d  = sign_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shreg_d = mag_s;
               acc_d   = {AW{1'b0}};
               count_d = {CW{1'b0}};
               sign_d  = in_neg_s;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            acc_d   = {acc_adj_s[AW-2:0], shreg_q[WIDTH-1]};
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the current state, so they trail it by one clock.
   always_comb begin
      done_d = (state_q == DONE);
      busy_d = (state_q != IDLE);
      bcd_d  = bcd_q;
      neg_d  = neg_q;
      if (state_q == DONE) begin
         bcd_d = acc_q;
         neg_d = sign_q;
      end else begin
         bcd_d = bcd_q;
         neg_d = neg_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= {WIDTH{1'b0}};
         acc_q   <= {AW{1'b0}};
         count_q <= {CW{1'b0}};
         sign_q  <= 1'b0;
         bcd_q   <= {AW{1'b0}};
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         sign_q  <= sign_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.neg  = neg_q;
   assign bus.bcd  = bcd_q;

endmodule
